// File: rtl/digit_pulse_word_receiver.sv
// digit_pulse_word_receiver: assembles serial LSB-first digits into parallel
// words using a one-hot digit-pulse timing vector, with sync-loss detection.
module digit_pulse_word_receiver #(
    parameter int WORD_BITS  = 36,
    parameter bit ALLOW_GAPS = 1'b1,
    parameter int ERR_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_BITS-1:0] digit_pulse,
    input  logic                 serial_in,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_valid,
    output logic                 locked,
    output logic                 sync_err,
    output logic [ERR_W-1:0]     err_count
);

    localparam int IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(WORD_BITS - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t                 state, state_d;
    logic [WORD_BITS-1:0]   shreg, shreg_d;
    logic [IDX_W-1:0]       expected, exp_d;
    logic [IDX_W-1:0]       idx;
    logic                   is_zero, is_multi, is_one;
    logic                   load, err;

    // Classify the timing vector and find the index of the set bit
    always_comb begin
        is_zero  = (digit_pulse == '0);
        is_multi = |(digit_pulse & (digit_pulse - WORD_BITS'(1)));
        is_one   = !is_zero && !is_multi;
        idx      = '0;
        for (int i = 0; i < WORD_BITS; i++) begin
            if (digit_pulse[i]) idx = IDX_W'(i);
        end
    end

    // Next-state, digit capture and word/error decisions
    always_comb begin
        state_d = state;
        shreg_d = shreg;
        exp_d   = expected;
        load    = 1'b0;
        err     = 1'b0;
        unique case (state)
            HUNT: begin
                if (is_one && idx == '0) begin
                    shreg_d    = '0;
                    shreg_d[0] = serial_in;
                    exp_d      = IDX_W'(1);
                    state_d    = RECV;
                end
            end
            RECV: begin
                if (is_one && idx == expected) begin
                    shreg_d[idx] = serial_in;
                    if (idx == LAST) begin
                        load  = 1'b1;
                        exp_d = '0;
                    end else begin
                        exp_d = expected + IDX_W'(1);
                    end
                end else if (is_zero && ALLOW_GAPS) begin
                    state_d = RECV;
                end else begin
                    // Erroneous ONE(0) must not restart a word here
                    err     = 1'b1;
                    state_d = HUNT;
                    shreg_d = '0;
                    exp_d   = '0;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_d;
    end

    // Datapath registers, strobes and saturating error counter
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            expected   <= '0;
            word       <= '0;
            word_valid <= 1'b0;
            sync_err   <= 1'b0;
            err_count  <= '0;
        end else begin
            shreg      <= shreg_d;
            expected   <= exp_d;
            word_valid <= load;
            sync_err   <= err;
            if (load) word <= shreg_d;
            if (err && err_count != '1) err_count <= err_count + ERR_W'(1);
        end
    end

    assign locked = (state == RECV);

endmodule

// File: tb/tb_digit_pulse_word_receiver.sv
// Randomised self-checking bench for digit_pulse_word_receiver,
// two instances: gaps allowed (u1) and gaps forbidden (u0).
module tb_digit_pulse_word_receiver;

    localparam int W = 36;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] digit_pulse = '0;
    logic         serial_in = 1'b0;

    logic [W-1:0] w1, w0;
    logic         v1, v0, l1, l0, e1, e0;
    logic [7:0]   c1, c0;

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    bit chk_en = 0;
    int vq[$];

    always #5 clk = ~clk;

    digit_pulse_word_receiver #(.WORD_BITS(W), .ALLOW_GAPS(1'b1), .ERR_W(8)) u1 (
        .clk(clk), .rst(rst), .digit_pulse(digit_pulse), .serial_in(serial_in),
        .word(w1), .word_valid(v1), .locked(l1), .sync_err(e1), .err_count(c1)
    );

    digit_pulse_word_receiver #(.WORD_BITS(W), .ALLOW_GAPS(1'b0), .ERR_W(8)) u0 (
        .clk(clk), .rst(rst), .digit_pulse(digit_pulse), .serial_in(serial_in),
        .word(w0), .word_valid(v0), .locked(l0), .sync_err(e0), .err_count(c0)
    );

    // Behavioural model: index 1 allows gaps, index 0 does not
    bit           mlocked[2];
    int           mcnt[2];
    logic [W-1:0] macc[2];
    logic [W-1:0] mword[2];
    bit           mvalid[2];
    bit           merr[2];
    int           merrcnt[2];

    task automatic model_step(input int m, input bit gaps);
        logic [W-1:0] one;
        int ones;
        one = 1;
        mvalid[m] = 0;
        merr[m]   = 0;
        if (rst) begin
            mlocked[m] = 0; mcnt[m] = 0; macc[m] = '0;
            mword[m] = '0; merrcnt[m] = 0;
            return;
        end
        ones = $countones(digit_pulse);
        if (!mlocked[m]) begin
            if (digit_pulse == one) begin
                mlocked[m] = 1;
                macc[m] = '0;
                macc[m][0] = serial_in;
                mcnt[m] = 1;
            end
        end else if (ones == 0 && gaps) begin
            mcnt[m] = mcnt[m];
        end else if (ones == 1 && digit_pulse == (one << mcnt[m])) begin
            macc[m] = macc[m] | (W'(serial_in) << mcnt[m]);
            mcnt[m]++;
            if (mcnt[m] == W) begin
                mword[m] = macc[m];
                mvalid[m] = 1;
                mcnt[m] = 0;
                macc[m] = '0;
            end
        end else begin
            merr[m] = 1;
            mlocked[m] = 0;
            mcnt[m] = 0;
            if (merrcnt[m] < 255) merrcnt[m]++;
        end
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            mlocked[m] = 0; mcnt[m] = 0; macc[m] = '0; mword[m] = '0;
            mvalid[m] = 0; merr[m] = 0; merrcnt[m] = 0;
        end
    end

    always @(posedge clk) begin
        model_step(0, 1'b0);
        model_step(1, 1'b1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        cyc_n++;
        if (chk_en) begin
            chk("u1.word", 64'(w1), 64'(mword[1]));
            chk("u1.word_valid", 64'(v1), 64'(mvalid[1]));
            chk("u1.locked", 64'(l1), 64'(mlocked[1]));
            chk("u1.sync_err", 64'(e1), 64'(merr[1]));
            chk("u1.err_count", 64'(c1), 64'(merrcnt[1]));
            chk("u0.word", 64'(w0), 64'(mword[0]));
            chk("u0.word_valid", 64'(v0), 64'(mvalid[0]));
            chk("u0.locked", 64'(l0), 64'(mlocked[0]));
            chk("u0.sync_err", 64'(e0), 64'(merr[0]));
            chk("u0.err_count", 64'(c0), 64'(merrcnt[0]));
            if (v1) vq.push_back(cyc_n);
        end
    end

    task automatic cyc(input logic [W-1:0] v, input logic s);
        digit_pulse = v;
        serial_in   = s;
        @(negedge clk);
    endtask

    task automatic digits(input logic [W-1:0] bits, input int lo, input int hi, input int gapmax);
        logic [W-1:0] one;
        one = 1;
        for (int i = lo; i <= hi; i++) begin
            int g;
            g = (gapmax > 0) ? int'($urandom_range(gapmax)) : 0;
            for (int k = 0; k < g; k++) cyc('0, 1'($urandom_range(1)));
            cyc(one << i, bits[i]);
        end
    endtask

    logic [W-1:0] rw;
    logic [W-1:0] one_c = 1;
    logic [W-1:0] rv;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        rst = 1'b0;
        chk_en = 1;
        chk("reset.word", 64'(w1), 64'h0);
        chk("reset.locked", 64'(l1), 64'h0);
        chk("reset.err_count", 64'(c1), 64'h0);

        // Clean word with even digits set
        digits(36'h555555555, 0, W-1, 0);
        chk("t1.word", 64'(w1), 64'h555555555);
        chk("t1.valid", 64'(v1), 64'h1);
        cyc('0, 1'b1);
        chk("t1.valid_drop", 64'(v1), 64'h0);

        // Random gaps
        digits(36'h800000001, 0, W-1, 3);
        chk("t2.word", 64'(w1), 64'h800000001);
        chk("t2.err_count", 64'(c1), 64'h0);

        // Digit 17 skipped
        digits(36'hFFFFFFFFF, 0, 16, 0);
        cyc(one_c << 18, 1'b1);
        chk("t3.sync_err", 64'(e1), 64'h1);
        chk("t3.err_count", 64'(c1), 64'h1);
        chk("t3.locked", 64'(l1), 64'h0);
        chk("t3.word_kept", 64'(w1), 64'h800000001);
        rw = {4'($urandom), 32'($urandom)};
        digits(rw, 0, W-1, 0);
        chk("t3.recover_word", 64'(w1), 64'(rw));

        // MULTI, and ZERO with gaps forbidden
        digits(rw, 0, 4, 0);
        cyc(36'h3, 1'b1);
        chk("t4.multi_err", 64'(e1), 64'h1);
        digits(rw, 0, 4, 0);
        cyc('0, 1'b1);
        chk("t4.gap_err_u0", 64'(e0), 64'h1);
        chk("t4.gap_ok_u1", 64'(e1), 64'h0);
        digits(rw, 5, W-1, 0);

        // Reset mid-word
        digits(36'hFFFFFFFFF, 0, 19, 0);
        rst = 1'b1;
        cyc(one_c << 20, 1'b1);
        rst = 1'b0;
        chk("t5.word", 64'(w1), 64'h0);
        chk("t5.locked", 64'(l1), 64'h0);
        chk("t5.err_count", 64'(c1), 64'h0);
        digits(36'hFFFFFFFFF, 21, W-1, 0);
        chk("t5.no_valid", 64'(v1), 64'h0);
        digits(36'h123456789, 0, W-1, 0);
        chk("t5.word_after", 64'(w1), 64'h123456789);

        // Saturation then back-to-back words
        for (int k = 0; k < 300; k++) begin
            cyc(one_c, 1'b0);
            cyc(36'h3, 1'b0);
        end
        chk("t6.saturated", 64'(c1), 64'd255);
        vq.delete();
        for (int k = 0; k < 3; k++) digits(rw ^ W'(k), 0, W-1, 0);
        cyc('0, 1'b0);
        chk("t6.valid_count", 64'(vq.size()), 64'd3);
        if (vq.size() == 3) begin
            chk("t6.spacing_a", 64'(vq[1] - vq[0]), 64'd36);
            chk("t6.spacing_b", 64'(vq[2] - vq[1]), 64'd36);
        end

        // Randomised traffic
        begin
            int n;
            int r;
            n = 0;
            for (int k = 0; k < 4000; k++) begin
                r = $urandom_range(199);
                if (r < 170) begin
                    cyc(one_c << n, 1'($urandom_range(1)));
                    n = (n + 1) % W;
                end else if (r < 190) begin
                    cyc('0, 1'($urandom_range(1)));
                end else if (r < 194) begin
                    rv = one_c << $urandom_range(W-1);
                    cyc(rv, 1'($urandom_range(1)));
                end else if (r < 198) begin
                    rv = (one_c << $urandom_range(W-1)) | (one_c << $urandom_range(W-1));
                    cyc(rv, 1'($urandom_range(1)));
                end else begin
                    rst = 1'b1;
                    cyc(one_c << n, 1'($urandom_range(1)));
                    rst = 1'b0;
                    n = 0;
                end
            end
        end

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
